multi_project_mux: RTL and testbench
====================================

MULTI_PROJECT_MUX -- requirements
Module: multi_project_mux

Interface
REQ-001 SHALL expose these parameters:
- NUM_PROJ, 4, number of project slots (2..16)
- IO_W, 33, pad bits routed per slot
- BASE_ADDR, 32'h3000_0000, Wishbone register base
- RST_HOLD, 8, reset-hold cycles (>=1)

REQ-002 SHALL expose these ports (name, direction, width, meaning):
- wb_clk_i, in, 1, sole clock
- wb_rst_i, in, 1, synchronous active-high reset
- wbs_cyc_i, in, 1, Wishbone cycle
- wbs_stb_i, in, 1, Wishbone strobe
- wbs_we_i, in, 1, Wishbone write enable
- wbs_sel_i, in, 4, byte lanes
- wbs_adr_i, in, 32, address
- wbs_dat_i, in, 32, write data
- wbs_ack_o, out, 1, acknowledge
- wbs_dat_o, out, 32, read data
- proj_do, in, NUM_PROJ*IO_W, slot outputs; slot k at [k*IO_W +: IO_W]
- proj_oeb, in, NUM_PROJ*IO_W, slot output enables, same packing
- io_out, out, IO_W, pad outputs
- io_oeb, out, IO_W, pad output enables (1 = input)
- proj_rst_n, out, NUM_PROJ, per-slot active-low reset
- custom_settings, out, 32, shared slot configuration
- irq, out, 1, switch-complete pulse

Function
REQ-003 SHALL provide registers at BASE_ADDR + offset:
- 0x0 CTRL (W)
- 0x4 STATUS (R)
- 0x8 SETTINGS (R/W)
REQ-004 SHALL handle every access with cyc&stb high and ack low as follows: exactly one wbs_ack_o pulse, registered one cycle later; wbs_dat_o valid in the ack cycle and 0 otherwise.
REQ-005 SHALL ack unmapped addresses, ignore writes to them, and return 0 on reads.
REQ-006 SHALL honour wbs_sel_i per byte for SETTINGS writes; custom_settings equals the SETTINGS register.
REQ-007 SHALL treat a CTRL write with wbs_sel_i[0]=1 as a switch request:
- target = wbs_dat_i[7:0]
- wbs_dat_i[31]=0, or target >= NUM_PROJ, means "none"
REQ-008 SHALL implement FSM states OFF, ISOLATE, HOLD and RUN.
REQ-009 In OFF or RUN, SHALL go to ISOLATE on a switch request; rewriting the running index restarts that slot.
REQ-010 ISOLATE SHALL last 1 cycle; on exit, SHALL load the hold counter with RST_HOLD-1 and enter HOLD.
REQ-011 HOLD SHALL decrement the counter each cycle; at 0 it SHALL go to RUN for a valid target, else to OFF.
REQ-012 SHALL drive io_oeb all ones and io_out zero in every state except RUN, starting in the cycle after the request is accepted.
REQ-013 In RUN SHALL set io_out = proj_do slot[active] and io_oeb = proj_oeb slot[active], combinationally from the slot inputs.
REQ-014 SHALL assert proj_rst_n[k]=1 only in RUN with k = active; all other bits SHALL be 0.
REQ-015 SHALL latch a request arriving in ISOLATE or HOLD as pending, one deep, with a later write replacing it.
REQ-016 If pending is set when the counter reaches 0, SHALL:
- adopt the pending target
- clear pending
- reload RST_HOLD-1
- remain in HOLD
REQ-017 SHALL pulse irq high for exactly 1 cycle on each HOLD->RUN or HOLD->OFF transition, and not on reloads.
REQ-018 SHALL define STATUS as:
- [7:0] active index (0xFF when none)
- [8] busy (ISOLATE/HOLD)
- [9] pending
- [10] running
- [13:12] state: OFF=0, ISOLATE=1, HOLD=2, RUN=3
- other bits 0

Reset
REQ-019 While wb_rst_i is high at a clock edge, SHALL set the following, and this SHALL also abort any sequence in progress:
- state OFF, active 0xFF, pending 0, counter 0
- SETTINGS 0
- wbs_ack_o 0, wbs_dat_o 0, irq 0
- proj_rst_n all 0, io_oeb all 1, io_out 0

Verification
REQ-020 Bench SHALL cover these directed scenarios:
- Reset release with no writes: io_oeb all 1, proj_rst_n=0, STATUS=0x00FF.
- CTRL write 0x8000_0002 (RST_HOLD=8): ISOLATE 1 cycle, HOLD 8 cycles, then proj_rst_n=4'b0100 with one irq pulse; io_out follows slot 2 and STATUS=0x34_02 form (running=1, state=3).
- In RUN slot 2, write 0x8000_0001, then during HOLD write 0x8000_0003: pending set, HOLD reloads, single irq, final proj_rst_n=4'b1000.
- CTRL write 0x8000_0009 (NUM_PROJ=4): sequence ends in OFF, STATUS[7:0]=0xFF, irq pulses once.
- SETTINGS write 0xA5A5_A5A5 with sel=4'b0011, then read back: custom_settings=0x0000_A5A5; unmapped read returns 0 with ack.
- wb_rst_i asserted mid-HOLD: next cycle state OFF, pending cleared, irq remains 0.

Source files
------------

// File: rtl/multi_project_mux.sv
// multi_project_mux: Wishbone-controlled selector that hands a shared bank of
// IO pads to one of NUM_PROJ project slots. A switch isolates the pads for one
// cycle, holds every slot in reset for RST_HOLD cycles, then releases the
// chosen slot and routes its pad outputs.
module multi_project_mux #(
  parameter int          NUM_PROJ  = 4,
  parameter int          IO_W      = 33,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          RST_HOLD  = 8
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     wbs_cyc_i,
  input  logic                     wbs_stb_i,
  input  logic                     wbs_we_i,
  input  logic [3:0]               wbs_sel_i,
  input  logic [31:0]              wbs_adr_i,
  input  logic [31:0]              wbs_dat_i,
  output logic                     wbs_ack_o,
  output logic [31:0]              wbs_dat_o,
  input  logic [NUM_PROJ*IO_W-1:0] proj_do,
  input  logic [NUM_PROJ*IO_W-1:0] proj_oeb,
  output logic [IO_W-1:0]          io_out,
  output logic [IO_W-1:0]          io_oeb,
  output logic [NUM_PROJ-1:0]      proj_rst_n,
  output logic [31:0]              custom_settings,
  output logic                     irq
);

  // State encoding doubles as the STATUS[13:12] field.
  localparam logic [1:0] S_OFF     = 2'd0;
  localparam logic [1:0] S_ISOLATE = 2'd1;
  localparam logic [1:0] S_HOLD    = 2'd2;
  localparam logic [1:0] S_RUN     = 2'd3;

  localparam int                CNT_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [7:0]        IDX_NONE = 8'hFF;

  localparam logic [31:0] ADDR_CTRL     = BASE_ADDR;
  localparam logic [31:0] ADDR_STATUS   = BASE_ADDR + 32'h4;
  localparam logic [31:0] ADDR_SETTINGS = BASE_ADDR + 32'h8;

  // Bus-side registers
  logic        r_ack;
  logic [31:0] r_dat;
  logic [31:0] r_settings;

  // Switch sequencer registers
  logic [1:0]       r_state;
  logic [7:0]       r_active;
  logic             r_pend;
  logic [7:0]       r_pend_idx;
  logic [CNT_W-1:0] r_cnt;
  logic             r_irq;

  // Decoded bus activity
  logic        w_access;
  logic        w_wr;
  logic        w_rd;
  logic        w_req;
  logic [7:0]  w_req_idx;
  logic [31:0] w_status;
  logic [31:0] w_rd_data;

  // A new access is one not already being acknowledged, so a held strobe
  // produces exactly one ack per transfer.
  assign w_access = wbs_cyc_i & wbs_stb_i & ~r_ack;
  assign w_wr     = w_access & wbs_we_i;
  assign w_rd     = w_access & ~wbs_we_i;
  assign w_req    = w_wr & (wbs_adr_i == ADDR_CTRL) & wbs_sel_i[0];

  // Out-of-range or disabled targets collapse to the "none" index so the
  // rest of the design only ever sees a valid slot or 0xFF.
  assign w_req_idx = (wbs_dat_i[31] && ({24'd0, wbs_dat_i[7:0]} < 32'(NUM_PROJ)))
                   ? wbs_dat_i[7:0] : IDX_NONE;

  assign w_status = {18'd0,
                     r_state,
                     1'b0,
                     (r_state == S_RUN),
                     r_pend,
                     ((r_state == S_ISOLATE) || (r_state == S_HOLD)),
                     r_active};

  // Read-data mux; CTRL is write-only and unmapped offsets read as zero.
  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch
    // is inferred for unlisted addresses.
    w_rd_data = '0;
    case (wbs_adr_i)
      ADDR_STATUS:   w_rd_data = w_status;
      ADDR_SETTINGS: w_rd_data = r_settings;
      default:       w_rd_data = '0;
    endcase
  end

  // Wishbone ack and read data, both valid only in the single ack cycle.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_access;
      r_dat <= w_rd ? w_rd_data : '0;
    end
  end

  // SETTINGS register with per-byte write enables.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_settings <= '0;
    end else if (w_wr && (wbs_adr_i == ADDR_SETTINGS)) begin
      for (int b = 0; b < 4; b++) begin
        if (wbs_sel_i[b]) r_settings[b*8 +: 8] <= wbs_dat_i[b*8 +: 8];
      end
    end
  end

  // Switch sequencer: OFF/RUN -> ISOLATE -> HOLD (with reloads) -> RUN/OFF.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state    <= S_OFF;
      r_active   <= IDX_NONE;
      r_pend     <= 1'b0;
      r_pend_idx <= IDX_NONE;
      r_cnt      <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_irq <= 1'b0;

      // Requests during a switch queue one deep; a later one overwrites.
      if (w_req && ((r_state == S_ISOLATE) || (r_state == S_HOLD))) begin
        r_pend     <= 1'b1;
        r_pend_idx <= w_req_idx;
      end

      case (r_state)
        S_OFF, S_RUN: begin
          if (w_req) begin
            r_state  <= S_ISOLATE;
            r_active <= w_req_idx;
          end
        end
        S_ISOLATE: begin
          r_cnt   <= CNT_LOAD;
          r_state <= S_HOLD;
        end
        S_HOLD: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_ONE;
          end else if (r_pend || w_req) begin
            // A request landing on the final hold cycle is adopted directly
            // rather than leaking into RUN/OFF as a stale pending bit.
            r_active <= w_req ? w_req_idx : r_pend_idx;
            r_pend   <= 1'b0;
            r_cnt    <= CNT_LOAD;
          end else begin
            r_state <= (r_active != IDX_NONE) ? S_RUN : S_OFF;
            r_irq   <= 1'b1;
          end
        end
        default: r_state <= S_OFF;
      endcase
    end
  end

  // Pad routing and slot resets; everything is isolated outside RUN.
  always_comb begin
    io_out     = '0;
    io_oeb     = '1;
    proj_rst_n = '0;
    if (r_state == S_RUN) begin
      for (int k = 0; k < NUM_PROJ; k++) begin
        if (r_active == 8'(k)) begin
          io_out        = proj_do[k*IO_W +: IO_W];
          io_oeb        = proj_oeb[k*IO_W +: IO_W];
          proj_rst_n[k] = 1'b1;
        end
      end
    end
  end

  assign wbs_ack_o       = r_ack;
  assign wbs_dat_o       = r_dat;
  assign custom_settings = r_settings;
  assign irq             = r_irq;

endmodule

// File: tb/tb_multi_project_mux.sv
// Directed testbench for multi_project_mux with hand-computed expectations.
module tb_multi_project_mux;

  localparam int          NP   = 4;
  localparam int          IOW  = 33;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic                wb_clk_i = 1'b0;
  logic                wb_rst_i = 1'b1;
  logic                wbs_cyc_i = 1'b0;
  logic                wbs_stb_i = 1'b0;
  logic                wbs_we_i = 1'b0;
  logic [3:0]          wbs_sel_i = '0;
  logic [31:0]         wbs_adr_i = '0;
  logic [31:0]         wbs_dat_i = '0;
  logic                wbs_ack_o;
  logic [31:0]         wbs_dat_o;
  logic [NP*IOW-1:0]   proj_do;
  logic [NP*IOW-1:0]   proj_oeb;
  logic [IOW-1:0]      io_out;
  logic [IOW-1:0]      io_oeb;
  logic [NP-1:0]       proj_rst_n;
  logic [31:0]         custom_settings;
  logic                irq;

  int n_checks = 0;
  int n_err    = 0;
  int cyc_n    = 0;

  multi_project_mux #(
    .NUM_PROJ (NP),
    .IO_W     (IOW),
    .BASE_ADDR(BASE),
    .RST_HOLD (8)
  ) dut (
    .wb_clk_i       (wb_clk_i),
    .wb_rst_i       (wb_rst_i),
    .wbs_cyc_i      (wbs_cyc_i),
    .wbs_stb_i      (wbs_stb_i),
    .wbs_we_i       (wbs_we_i),
    .wbs_sel_i      (wbs_sel_i),
    .wbs_adr_i      (wbs_adr_i),
    .wbs_dat_i      (wbs_dat_i),
    .wbs_ack_o      (wbs_ack_o),
    .wbs_dat_o      (wbs_dat_o),
    .proj_do        (proj_do),
    .proj_oeb       (proj_oeb),
    .io_out         (io_out),
    .io_oeb         (io_oeb),
    .proj_rst_n     (proj_rst_n),
    .custom_settings(custom_settings),
    .irq            (irq)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  always @(posedge wb_clk_i) cyc_n <= cyc_n + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One-cycle registered ack: request sampled at the next edge, ack seen #1 after.
  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    @(posedge wb_clk_i); #1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
    @(posedge wb_clk_i); #1;
    check("wr_ack", 64'(wbs_ack_o), 64'd1);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = '0;
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] dat);
    @(posedge wb_clk_i); #1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
    wbs_adr_i = adr;  wbs_sel_i = 4'hF;
    @(posedge wb_clk_i); #1;
    check("rd_ack", 64'(wbs_ack_o), 64'd1);
    dat = wbs_dat_o;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_sel_i = '0;
  endtask

  // Steps clock until irq is seen; returns cycle stamp or -1 on timeout.
  task automatic wait_irq(input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(posedge wb_clk_i); #1;
      if (irq) begin
        at = cyc_n;
        break;
      end
    end
  endtask

  initial begin
    logic [31:0] rd;
    int t0;
    int t_irq;
    int n_irq;

    for (int k = 0; k < NP; k++) begin
      proj_do[k*IOW +: IOW]  = 33'h1_0000_0000 | 33'(k * 32'h1111_1111);
      proj_oeb[k*IOW +: IOW] = 33'(32'h0F0F_0000 + k);
    end

    // Reset state
    repeat (3) @(posedge wb_clk_i);
    #1;
    check("rst_ack", 64'(wbs_ack_o), 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    wb_rst_i = 1'b0;
    check("rst_oeb", 64'(io_oeb), 64'h1_FFFF_FFFF);
    check("rst_out", 64'(io_out), 64'd0);
    check("rst_prst", 64'(proj_rst_n), 64'd0);
    check("rst_settings", 64'(custom_settings), 64'd0);
    wb_read(BASE + 32'h4, rd);
    check("rst_status", 64'(rd), 64'h0000_00FF);

    // Switch to slot 2
    wb_write(BASE, 32'h8000_0002, 4'h1);
    t0 = cyc_n;
    check("s2_isolate_state", 64'(dut.r_state), 64'd1);
    check("s2_isolate_oeb", 64'(io_oeb), 64'h1_FFFF_FFFF);
    check("s2_isolate_prst", 64'(proj_rst_n), 64'd0);
    @(posedge wb_clk_i); #1;
    check("s2_hold_state", 64'(dut.r_state), 64'd2);
    wait_irq(40, t_irq);
    check("s2_irq_latency", 64'(t_irq - t0), 64'd9);
    check("s2_prst", 64'(proj_rst_n), 64'b0100);
    check("s2_io_out", 64'(io_out), 64'h1_2222_2222);
    check("s2_io_oeb", 64'(io_oeb), 64'h0_0F0F_0002);
    proj_do[2*IOW +: IOW] = 33'h0_5A5A_0FF0;
    proj_do[1*IOW +: IOW] = 33'h1_DEAD_BEEF;
    #1;
    check("s2_io_follow", 64'(io_out), 64'h0_5A5A_0FF0);
    @(posedge wb_clk_i); #1;
    check("s2_irq_single", 64'(irq), 64'd0);
    wb_read(BASE + 32'h4, rd);
    check("s2_status", 64'(rd), 64'h0000_3402);

    // Switch to slot 1, superseded by slot 3 during HOLD
    wb_write(BASE, 32'h8000_0001, 4'h1);
    t0 = cyc_n;
    check("s3_isolate_out", 64'(io_out), 64'd0);
    check("s3_isolate_prst", 64'(proj_rst_n), 64'd0);
    wb_read(BASE + 32'h4, rd);
    check("s3_status_hold", 64'(rd), 64'h0000_2101);
    wb_write(BASE, 32'h8000_0003, 4'h1);
    wb_read(BASE + 32'h4, rd);
    check("s3_status_pend", 64'(rd), 64'h0000_2301);
    wait_irq(40, t_irq);
    check("s3_irq_latency", 64'(t_irq - t0), 64'd17);
    check("s3_prst", 64'(proj_rst_n), 64'b1000);
    check("s3_io_out", 64'(io_out), 64'h1_3333_3333);
    @(posedge wb_clk_i); #1;
    check("s3_irq_single", 64'(irq), 64'd0);

    // Out-of-range target ends in OFF
    wb_write(BASE, 32'h8000_0009, 4'h1);
    t0 = cyc_n;
    n_irq = 0;
    wait_irq(40, t_irq);
    check("s4_irq_latency", 64'(t_irq - t0), 64'd9);
    for (int i = 0; i < 10; i++) begin
      @(posedge wb_clk_i); #1;
      if (irq) n_irq++;
    end
    check("s4_irq_extra", 64'(n_irq), 64'd0);
    check("s4_prst", 64'(proj_rst_n), 64'd0);
    check("s4_oeb", 64'(io_oeb), 64'h1_FFFF_FFFF);
    wb_read(BASE + 32'h4, rd);
    check("s4_status", 64'(rd), 64'h0000_00FF);

    // SETTINGS byte lanes and unmapped accesses
    wb_write(BASE + 32'h8, 32'hA5A5_A5A5, 4'b0011);
    check("s5_settings_lo", 64'(custom_settings), 64'h0000_A5A5);
    wb_write(BASE + 32'h10, 32'hFFFF_FFFF, 4'hF);
    check("s5_unmapped_wr", 64'(custom_settings), 64'h0000_A5A5);
    wb_write(BASE + 32'h8, 32'hFF00_0000, 4'b1000);
    check("s5_settings_hi", 64'(custom_settings), 64'hFF00_A5A5);
    wb_read(BASE + 32'h8, rd);
    check("s5_settings_rd", 64'(rd), 64'hFF00_A5A5);
    @(posedge wb_clk_i); #1;
    check("s5_ack_drop", 64'(wbs_ack_o), 64'd0);
    check("s5_dat_idle", 64'(wbs_dat_o), 64'd0);
    wb_read(BASE + 32'hC, rd);
    check("s5_unmapped_rd", 64'(rd), 64'd0);
    wb_read(BASE, rd);
    check("s5_ctrl_rd", 64'(rd), 64'd0);

    // Reset mid-HOLD aborts the sequence
    wb_write(BASE, 32'h8000_0000, 4'h1);
    wb_write(BASE, 32'h8000_0002, 4'h1);
    check("s6_pend_before", 64'(dut.r_pend), 64'd1);
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i); #1;
    check("s6_state", 64'(dut.r_state), 64'd0);
    check("s6_pend", 64'(dut.r_pend), 64'd0);
    check("s6_irq", 64'(irq), 64'd0);
    check("s6_prst", 64'(proj_rst_n), 64'd0);
    check("s6_oeb", 64'(io_oeb), 64'h1_FFFF_FFFF);
    check("s6_settings", 64'(custom_settings), 64'd0);
    wb_rst_i = 1'b0;
    n_irq = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge wb_clk_i); #1;
      if (irq) n_irq++;
    end
    check("s6_no_irq", 64'(n_irq), 64'd0);
    wb_read(BASE + 32'h4, rd);
    check("s6_status", 64'(rd), 64'h0000_00FF);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
